// File: rtl/ysyx_22040000_lsu.sv
// Load/store unit: one memory op at a time, IDLE->REQ->WAIT->DONE.
// Optional macro LSU_MISALIGN_CHECK_EN short-circuits misaligned ops to DONE.
//
// Ports:
//   in_*   : op from EXU (valid/ready; addr, wdata, we, size, unsigned)
//   req_*  : data-memory request (valid/ready; we, addr, wdata, wstrb)
//   rsp_*  : data-memory response (valid/ready; rdata)
//   out_*  : result to write-back (valid/ready; rdata, misalign)
module ysyx_22040000_lsu #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_addr,
  input  logic [DWIDTH-1:0] in_wdata,
  input  logic              in_we,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [DWIDTH-1:0] req_addr,
  output logic [DWIDTH-1:0] req_wdata,
  output logic [3:0]        req_wstrb,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  input  logic [DWIDTH-1:0] rsp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_rdata,
  output logic              out_misalign
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [DWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [DWIDTH-1:0] rdata_q;
  logic              mis_q;

  logic              mis_in;
  logic              accept;
  logic              is_b;
  logic              is_h;
  logic [DWIDTH-1:0] shifted;
  logic [DWIDTH-1:0] load_fmt;
  logic [3:0]        strb_base;

`ifdef LSU_MISALIGN_CHECK_EN
  assign mis_in = (in_size == 2'b01 && in_addr[0])
               || (in_size[1] && in_addr[1:0] != 2'b00);
`else
  assign mis_in = 1'b0;
`endif

  assign accept = (state == IDLE) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (in_valid) state_n = mis_in ? DONE : REQ;
      REQ:  if (req_ready) state_n = WAIT;
      WAIT: if (rsp_valid) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
        we_q    <= in_we;
        size_q  <= in_size;
        uns_q   <= in_unsigned;
        rdata_q <= '0;
        mis_q   <= mis_in;
      end
      if (state == WAIT && rsp_valid) begin
        rdata_q <= we_q ? '0 : load_fmt;
      end
    end
  end

  assign is_b = (size_q == 2'b00);
  assign is_h = (size_q == 2'b01);

  // Lanes above byte 3 shift in as zero.
  assign shifted = rsp_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_fmt = shifted;
    unique case (1'b1)
      is_b: load_fmt = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      is_h: load_fmt = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: load_fmt = shifted;
    endcase
  end

  always_comb begin
    req_wdata = wdata_q;
    strb_base = 4'b1111;
    unique case (1'b1)
      is_b: begin
        req_wdata = {4{wdata_q[7:0]}};
        strb_base = 4'b0001;
      end
      is_h: begin
        req_wdata = {2{wdata_q[15:0]}};
        strb_base = 4'b0011;
      end
      default: begin
        req_wdata = wdata_q;
        strb_base = 4'b1111;
      end
    endcase
  end

  assign req_wstrb = we_q ? (strb_base << addr_q[1:0]) : 4'b0000;
  assign req_addr  = {addr_q[DWIDTH-1:2], 2'b00};
  assign req_we    = we_q;

  assign in_ready  = (state == IDLE);
  assign req_valid = (state == REQ);
  assign rsp_ready = (state == WAIT);
  assign out_valid = (state == DONE);
  assign out_rdata = rdata_q;

`ifdef LSU_MISALIGN_CHECK_EN
  assign out_misalign = mis_q;
`else
  assign out_misalign = 1'b0;
`endif

endmodule
